// File: rtl/booth_display_pkg.sv
// Shared definitions for the Booth multiplier display path.
// Provides the converter state encoding, the BCD digit width, the default
// product width / digit count used by the display multiplexer, and a small
// digit helper.
package booth_display_pkg;

    localparam int BCD_W      = 4;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // True when a BCD digit carries a nonzero value.
    function automatic logic digit_nonzero(input logic [BCD_W-1:0] digit);
        return |digit;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more so
// that the following left shift carries correctly into the next decade.
// Ports:
//   digit_i  4-bit working BCD digit before the shift
//   digit_o  corrected digit
module bcd_digit_adjust
    import booth_display_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);

    // Add-3 correction; digits never exceed 9 here, so no 4-bit wrap occurs.
    always_comb begin
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter turning the signed Booth product into
// decimal BCD digits, a sign flag and a leading-zero blanking mask.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   start     conversion request, honoured only in IDLE
//   value     binary input, captured on the accepting edge
//   busy      high while a conversion is in flight
//   done      one-cycle pulse when bcd/negative/digit_en are updated
//   bcd       digit i in bits [4i+3:4i], digit 0 = units
//   negative  sign of the converted value (always 0 when SIGNED=0)
//   digit_en  bit i set when digit i is significant; bit 0 always set
module result_bcd_converter
    import booth_display_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS,
    parameter int SIGNED = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIDTH-1:0]        value,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    negative,
    output logic [DIGITS-1:0]       digit_en
);

    localparam int CNT_W    = $clog2(WIDTH + 1);
    localparam int BCD_BITS = BCD_W * DIGITS;

    conv_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    mag_q, mag_d;
    logic [BCD_BITS-1:0] work_q, work_d;
    logic                sign_q, sign_d;
    logic [BCD_BITS-1:0] bcd_q, bcd_d;
    logic                neg_q, neg_d;
    logic [DIGITS-1:0]   en_q, en_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [BCD_BITS-1:0] adj_s;
    logic [DIGITS-1:0]   en_calc_s;
    logic                is_neg_s;
    logic [WIDTH-1:0]    abs_s;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit_i (work_q[g*BCD_W +: BCD_W]),
                .digit_o (adj_s[g*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // Magnitude of the incoming value; ~v+1 of the most negative input is
    // its own unsigned magnitude, so no extra bit is needed.
    always_comb begin
        if ((SIGNED != 0) && value[WIDTH-1]) begin
            is_neg_s = 1'b1;
            abs_s    = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            is_neg_s = 1'b0;
            abs_s    = value;
        end
    end

    // Blanking mask: a digit is significant if it or any higher digit is nonzero.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        en_calc_s = {DIGITS{1'b0}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen         = seen | digit_nonzero(work_q[i*BCD_W +: BCD_W]);
            en_calc_s[i] = seen;
        end
        en_calc_s[0] = 1'b1;
    end

    // FSM next-state, shift datapath and output-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        work_d  = work_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        en_d    = en_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mag_d   = abs_s;
                    sign_d  = is_neg_s;
                    work_d  = {BCD_BITS{1'b0}};
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Corrected digits and magnitude shift left as one long register.
                work_d = {adj_s[BCD_BITS-2:0], mag_q[WIDTH-1]};
                mag_d  = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                bcd_d   = work_q;
                neg_d   = sign_q;
                en_d    = en_calc_s;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            mag_q   <= {WIDTH{1'b0}};
            work_q  <= {BCD_BITS{1'b0}};
            sign_q  <= 1'b0;
            bcd_q   <= {BCD_BITS{1'b0}};
            neg_q   <= 1'b0;
            en_q    <= {DIGITS{1'b0}};
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            work_q  <= work_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            en_q    <= en_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign negative = neg_q;
    assign digit_en = en_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Self-checking bench for result_bcd_converter: one signed and one unsigned
// instance, fixed scenarios plus random values checked against a decimal model.
module tb_result_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s, start_u;
    logic [15:0] value_s, value_u;
    logic        busy_s, done_s, neg_s, busy_u, done_u, neg_u;
    logic [19:0] bcd_s, bcd_u;
    logic [4:0]  en_s, en_u;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    result_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) u_s (
        .clk(clk), .rst(rst), .start(start_s), .value(value_s), .busy(busy_s),
        .done(done_s), .bcd(bcd_s), .negative(neg_s), .digit_en(en_s)
    );

    result_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_u (
        .clk(clk), .rst(rst), .start(start_u), .value(value_u), .busy(busy_u),
        .done(done_u), .bcd(bcd_u), .negative(neg_u), .digit_en(en_u)
    );

    // Decimal reference: digits by division, significance by magnitude >= 10^i.
    function automatic void model(input logic [15:0] v, input bit uns,
                                  output logic [19:0] b, output logic n, output logic [4:0] e);
        int m;
        int p;
        n = !uns && v[15];
        m = n ? (65536 - int'(v)) : int'(v);
        p = 1;
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'((m / p) % 10);
            e[i] = (m >= p);
            p = p * 10;
        end
        e[0] = 1'b1;
    endfunction

    // Drive one start pulse and wait (bounded) for done; lat counts edges
    // from acceptance to done, bc counts busy-high samples.
    task automatic conv(input bit uns, input logic [15:0] v, output int lat, output int bc);
        @(negedge clk);
        if (uns) begin start_u = 1'b1; value_u = v; end
        else     begin start_s = 1'b1; value_s = v; end
        @(posedge clk); #1;
        start_u = 1'b0; start_s = 1'b0;
        value_u = 16'($urandom); value_s = 16'($urandom);
        lat = 0;
        bc  = (uns ? busy_u : busy_s) ? 1 : 0;
        while (!(uns ? done_u : done_s) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (uns ? busy_u : busy_s) bc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start_s = 1'b0; start_u = 1'b0; value_s = 16'h0; value_u = 16'h0;
        repeat (3) @(negedge clk);
        total++; if ({busy_s, done_s, neg_s} !== 3'b000) begin bad++; $display("FAIL reset_flags_s got=%b exp=000", {busy_s, done_s, neg_s}); end
        total++; if (bcd_s !== 20'h0) begin bad++; $display("FAIL reset_bcd_s got=%h exp=00000", bcd_s); end
        total++; if (en_s !== 5'b0) begin bad++; $display("FAIL reset_en_s got=%b exp=00000", en_s); end
        total++; if ({busy_u, done_u, neg_u, bcd_u, en_u} !== 28'h0) begin bad++; $display("FAIL reset_u got=%h exp=0", {busy_u, done_u, neg_u, bcd_u, en_u}); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if ({busy_s, done_s, bcd_s} !== 22'h0) begin bad++; $display("FAIL reset_release got=%h exp=0", {busy_s, done_s, bcd_s}); end
    endtask

    task automatic test_basic();
        int lat, bc;
        conv(1'b0, 16'h04D2, lat, bc);
        total++; if (lat !== 17) begin bad++; $display("FAIL basic_latency got=%0d exp=17", lat); end
        total++; if (bc !== 17) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=17", bc); end
        total++; if (bcd_s !== 20'h01234) begin bad++; $display("FAIL basic_bcd got=%h exp=01234", bcd_s); end
        total++; if (neg_s !== 1'b0) begin bad++; $display("FAIL basic_neg got=%b exp=0", neg_s); end
        total++; if (en_s !== 5'b01111) begin bad++; $display("FAIL basic_en got=%b exp=01111", en_s); end
        @(posedge clk); #1;
        total++; if (done_s !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done_s); end
        total++; if (bcd_s !== 20'h01234) begin bad++; $display("FAIL basic_hold got=%h exp=01234", bcd_s); end
    endtask

    task automatic test_signed();
        int lat, bc;
        conv(1'b0, 16'hC000, lat, bc);
        total++; if (bcd_s !== 20'h16384) begin bad++; $display("FAIL neg_bcd got=%h exp=16384", bcd_s); end
        total++; if (neg_s !== 1'b1) begin bad++; $display("FAIL neg_flag got=%b exp=1", neg_s); end
        total++; if (en_s !== 5'b11111) begin bad++; $display("FAIL neg_en got=%b exp=11111", en_s); end
        conv(1'b0, 16'h8000, lat, bc);
        total++; if (bcd_s !== 20'h32768) begin bad++; $display("FAIL minneg_bcd got=%h exp=32768", bcd_s); end
        total++; if (neg_s !== 1'b1) begin bad++; $display("FAIL minneg_flag got=%b exp=1", neg_s); end
    endtask

    task automatic test_zero_unsigned();
        int lat, bc;
        conv(1'b0, 16'h0000, lat, bc);
        total++; if (bcd_s !== 20'h00000) begin bad++; $display("FAIL zero_bcd got=%h exp=00000", bcd_s); end
        total++; if (neg_s !== 1'b0) begin bad++; $display("FAIL zero_neg got=%b exp=0", neg_s); end
        total++; if (en_s !== 5'b00001) begin bad++; $display("FAIL zero_en got=%b exp=00001", en_s); end
        conv(1'b1, 16'hFFFF, lat, bc);
        total++; if (lat !== 17) begin bad++; $display("FAIL uns_latency got=%0d exp=17", lat); end
        total++; if (bcd_u !== 20'h65535) begin bad++; $display("FAIL uns_bcd got=%h exp=65535", bcd_u); end
        total++; if (neg_u !== 1'b0) begin bad++; $display("FAIL uns_neg got=%b exp=0", neg_u); end
        total++; if (en_u !== 5'b11111) begin bad++; $display("FAIL uns_en got=%b exp=11111", en_u); end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [15:0] v;
        logic [19:0] eb;
        logic en_n;
        logic [4:0] ee;
        bit uns;
        for (int k = 0; k < 24; k++) begin
            v   = 16'($urandom);
            uns = bit'($urandom_range(0, 1));
            model(v, uns, eb, en_n, ee);
            conv(uns, v, lat, bc);
            total++; if (lat !== 17) begin bad++; $display("FAIL rnd_latency v=%h got=%0d exp=17", v, lat); end
            total++;
            if ((uns ? {bcd_u, neg_u, en_u} : {bcd_s, neg_s, en_s}) !== {eb, en_n, ee}) begin
                bad++;
                $display("FAIL rnd_result v=%h uns=%0d got=%h/%b/%b exp=%h/%b/%b", v, uns,
                         uns ? bcd_u : bcd_s, uns ? neg_u : neg_s, uns ? en_u : en_s, eb, en_n, ee);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, gap;
        @(negedge clk); start_s = 1'b1; value_s = 16'd5000;
        @(posedge clk); #1; start_s = 1'b0;
        lat = 0;
        while (!done_s && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin start_s = 1'b1; value_s = 16'd999; end
            else if (lat == 6) begin start_s = 1'b0; value_s = 16'($urandom); end
        end
        total++; if (lat !== 17) begin bad++; $display("FAIL ignore_latency got=%0d exp=17", lat); end
        total++; if (bcd_s !== 20'h05000) begin bad++; $display("FAIL ignore_bcd got=%h exp=05000", bcd_s); end
        // Still in the done cycle: this start must be accepted.
        start_s = 1'b1; value_s = 16'd7;
        @(posedge clk); #1; start_s = 1'b0; value_s = 16'($urandom);
        gap = 1;
        total++; if ({busy_s, bcd_s} !== {1'b1, 20'h05000}) begin bad++; $display("FAIL b2b_hold got=%b/%h exp=1/05000", busy_s, bcd_s); end
        while (!done_s && gap < 40) begin @(posedge clk); #1; gap++; end
        total++; if (gap !== 18) begin bad++; $display("FAIL b2b_gap got=%0d exp=18", gap); end
        total++; if (bcd_s !== 20'h00007) begin bad++; $display("FAIL b2b_bcd got=%h exp=00007", bcd_s); end
        total++; if (en_s !== 5'b00001) begin bad++; $display("FAIL b2b_en got=%b exp=00001", en_s); end
    endtask

    task automatic test_continuous();
        int lat, gap;
        logic [15:0] v1;
        logic [19:0] eb;
        logic en_n;
        logic [4:0] ee;
        v1 = 16'($urandom);
        @(negedge clk); start_s = 1'b1; value_s = v1;
        @(posedge clk); #1; value_s = 16'd4321;
        lat = 0;
        while (!done_s && lat < 40) begin @(posedge clk); #1; lat++; end
        model(v1, 1'b0, eb, en_n, ee);
        total++; if ({lat, bcd_s, neg_s, en_s} !== {17, eb, en_n, ee}) begin bad++; $display("FAIL hold1 v=%h got=%0d/%h/%b/%b exp=17/%h/%b/%b", v1, lat, bcd_s, neg_s, en_s, eb, en_n, ee); end
        gap = 0;
        while ((gap == 0 || !done_s) && gap < 40) begin @(posedge clk); #1; gap++; end
        start_s = 1'b0;
        total++; if (gap !== 18) begin bad++; $display("FAIL hold_gap got=%0d exp=18", gap); end
        total++; if ({bcd_s, neg_s, en_s} !== {20'h04321, 1'b0, 5'b01111}) begin bad++; $display("FAIL hold2 got=%h/%b/%b exp=04321/0/01111", bcd_s, neg_s, en_s); end
        @(posedge clk); #1;
        total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL hold_stop got=%b exp=0", busy_s); end
    endtask

    task automatic test_reset_midway();
        int lat, bc, seen;
        @(negedge clk); start_s = 1'b1; value_s = 16'h0999;
        @(posedge clk); #1; start_s = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++; if ({busy_s, done_s, neg_s} !== 3'b000) begin bad++; $display("FAIL arst_flags got=%b exp=000", {busy_s, done_s, neg_s}); end
        total++; if ({bcd_s, en_s} !== 25'h0) begin bad++; $display("FAIL arst_out got=%h/%b exp=0/0", bcd_s, en_s); end
        total++; if ({bcd_u, en_u} !== 25'h0) begin bad++; $display("FAIL arst_out_u got=%h/%b exp=0/0", bcd_u, en_u); end
        @(negedge clk); rst = 1'b1;
        seen = 0;
        repeat (25) begin @(posedge clk); #1; if (done_s || busy_s) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL arst_no_done got=%0d exp=0", seen); end
        conv(1'b0, 16'hFFFF, lat, bc);
        total++; if ({lat, bcd_s, neg_s, en_s} !== {17, 20'h00001, 1'b1, 5'b00001}) begin bad++; $display("FAIL arst_after got=%0d/%h/%b/%b exp=17/00001/1/00001", lat, bcd_s, neg_s, en_s); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_zero_unsigned();
        test_random();
        test_back_to_back();
        test_continuous();
        test_reset_midway();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
- Converts the signed binary product from the Booth multiplier into decimal BCD digits plus a sign flag for the 7-segment display path.
- It runs in the opposite direction to keypad operand entry, which accumulates decimal digits into binary.
- It is a sequential double-dabble (shift-add-3) converter with a start/busy/done handshake.
- Display/control logic pulses start when a product is ready and holds the converted digits for display.

Parameters:
- WIDTH, 16, width of the binary input (Booth product of two 8-bit operands).
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH.
- SIGNED, 1, 1 = value is two's complement; 0 = value is unsigned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- value  input  WIDTH  binary number; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress (state != IDLE).
- done  output  1  one-cycle pulse; outputs are valid from this cycle on.
- bcd  output  4*DIGITS  digit i in bits [4i+3:4i]; digit 0 = units.
- negative  output  1  1 when the converted value was negative (SIGNED=1 only).
- digit_en  output  DIGITS  leading-zero blanking mask; bit i = 1 if digit i is significant.

Behaviour:
- Reset (rst low, asynchronous, any state): state=IDLE, counter=0, shift registers=0; bcd=0, negative=0, digit_en=0, done=0, busy=0. An in-flight conversion is abandoned; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: capture mag = |value|, then go to SHIFT.
  - mag = value when SIGNED=0 or value MSB=0; otherwise mag = (~value)+1 (WIDTH-bit unsigned), and a sign flag is latched.
  - Same edge: working BCD register cleared, counter=WIDTH.
- SHIFT, one bit per cycle:
  - Every working digit >= 5 gets +3.
  - Then {bcd_work, mag} shifts left by 1 and counter decrements.
  - After exactly WIDTH SHIFT edges, go to DONE.
- DONE:
  - On the next edge, bcd <= working register, negative <= sign flag, and digit_en is computed from the final digits.
  - digit_en bit i = 1 if any digit at index >= i is nonzero; bit 0 is always 1.
  - Same edge: done=1 and state -> IDLE.
- done falls on the following edge, unless a new conversion completes there, which is impossible given the latency.
- Latency: start accepted at edge k -> done high from edge k+WIDTH+1 for exactly one cycle (17 cycles for WIDTH=16).
- Output hold: bcd/negative/digit_en hold their values until the next DONE edge and are not cleared at start.
- start while busy (SHIFT or DONE) is ignored, not queued.
- start high during the done cycle (state already IDLE) is accepted: back-to-back conversions every WIDTH+2 cycles.
- start held high continuously restarts immediately after each completion.
- Most-negative input (0x8000, SIGNED=1): mag = 32768, negative=1, no overflow.
- Zero: bcd=0, negative=0, digit_en=00001.
- value changes after the accepting edge do not affect the conversion in progress.

Decomposition:
- Shared package booth_display_pkg:
  - state enum conv_state_t {IDLE, SHIFT, DONE};
  - BCD_W=4;
  - default DIGITS/WIDTH constants used by the display multiplexer.
- One sub-module: bcd_digit_adjust. Combinational, 4-bit in/out, add 3 if input >= 5. Instantiated DIGITS times via generate.
- FSM, counter and output registers stay in result_bcd_converter.

Test Plan:
- value=1234 (0x04D2), start pulse -> done exactly 17 cycles later; bcd digits 4..0 = 0,1,2,3,4; negative=0; digit_en=01111; busy high for 17 cycles.
- value=0xC000 (-16384), SIGNED=1 -> bcd=16384, negative=1, digit_en=11111; then value=0x8000 -> bcd=32768, negative=1.
- value=0 -> bcd=00000, negative=0, digit_en=00001; second case SIGNED=0, value=0xFFFF -> bcd=65535, negative=0.
- start re-pulsed at cycle 5 of a conversion with a different value -> ignored; the first result is delivered. start high during the done cycle with value=7 -> a second done 18 cycles after the first, bcd=00007, digit_en=00001.
- rst asserted low at cycle 8 of a conversion -> all outputs 0 immediately (asynchronously); no done pulse after release. A new start then converts correctly (value=-1 -> bcd=00001, negative=1).
